pc_exc_unit: RTL and testbench

- Program-counter and exception-sequencing stage directly upstream of the control unit in the single-cycle exception/interrupt CPU.
- Holds the PC that addresses instruction memory; the fetched Op/Func are decoded by the control unit.
- Consumes the control unit's Pcsrc, plus the branch offset, jump target and exception sources, to compute the next PC.
- Owns the EPC, Cause and Status registers: takes synchronous exceptions and masked external interrupts, and returns via Eret.

---
 rtl/pc_exc_unit_if.sv | 28 ++
 rtl/pc_exc_unit.sv | 100 ++++++++++
 tb/tb_pc_exc_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_exc_unit_if.sv
// Bundle of the PC/exception stage: control-unit and exception inputs, PC and CP0-style outputs.
interface pc_exc_unit_if;
    logic        Stall;
    logic [1:0]  Pcsrc;
    logic [15:0] Imm16;
    logic [25:0] JAddr;
    logic        Ovf;
    logic        Unimpl;
    logic        Eret;
    logic        Intr;
    logic        Sts_we;
    logic [1:0]  Sts_wdata;
    logic [31:0] PC;
    logic [31:0] Pc4;
    logic [31:0] EPC;
    logic [1:0]  Cause;
    logic [1:0]  Status;
    logic        IntAck;

    modport master (
        output Stall, Pcsrc, Imm16, JAddr, Ovf, Unimpl, Eret, Intr, Sts_we, Sts_wdata,
        input  PC, Pc4, EPC, Cause, Status, IntAck
    );
    modport slave (
        input  Stall, Pcsrc, Imm16, JAddr, Ovf, Unimpl, Eret, Intr, Sts_we, Sts_wdata,
        output PC, Pc4, EPC, Cause, Status, IntAck
    );
endinterface

// File: rtl/pc_exc_unit.sv
// PC register plus EPC/Cause/Status exception sequencing with an interrupt pending latch.
// Build option VECTORED_EXC_EN: handler entry = EXC_VECTOR + (Cause << 3).
module pc_exc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0008
) (
    input  logic          Clk,
    input  logic          Rst,
    pc_exc_unit_if.slave  bus
);
    // The FSM state is the Status.EXL bit.
    typedef enum logic {RUN = 1'b0, HANDLER = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, epc_q, epc_d;
    logic [31:0] pc4, br_off, seq_pc, vec;
    logic [1:0]  cause_q, cause_d, vec_cause;
    logic        ie_q, ie_d, pend_q, pend_d, ack_q, ack_d;
    logic        exc, int_ok, take_int;

    always_comb begin
        pc4    = pc_q + 32'd4;
        br_off = {{14{bus.Imm16[15]}}, bus.Imm16, 2'b00};
        case (bus.Pcsrc)
            2'b10:   seq_pc = pc4 + br_off;
            2'b11:   seq_pc = {pc4[31:28], bus.JAddr, 2'b00};
            default: seq_pc = pc4;
        endcase
        exc       = ~bus.Stall & (bus.Ovf | bus.Unimpl);
        int_ok    = pend_q & ie_q & (state_q == RUN);
        take_int  = ~bus.Stall & ~exc & int_ok;
        vec_cause = exc ? (bus.Ovf ? 2'd2 : 2'd1) : 2'd0;
`ifdef VECTORED_EXC_EN
        vec = EXC_VECTOR + {27'd0, vec_cause, 3'b000};
`else
        vec = EXC_VECTOR;
`endif
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        ie_d    = ie_q;
        ack_d   = 1'b0;
        // A request still asserted on the taking edge re-arms the latch.
        pend_d  = (pend_q & ~take_int) | bus.Intr;
        if (!bus.Stall) begin
            if (exc) begin
                pc_d    = vec;
                cause_d = vec_cause;
                if (state_q == RUN) epc_d = pc_q;
                state_d = HANDLER;
            end else if (int_ok) begin
                pc_d    = vec;
                epc_d   = seq_pc;
                cause_d = 2'd0;
                state_d = HANDLER;
                ack_d   = 1'b1;
            end else if (bus.Eret) begin
                pc_d    = epc_q;
                state_d = RUN;
            end else if (bus.Sts_we) begin
                pc_d    = seq_pc;
                ie_d    = bus.Sts_wdata[0];
                state_d = bus.Sts_wdata[1] ? HANDLER : RUN;
            end else begin
                pc_d    = seq_pc;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            epc_q   <= 32'd0;
            cause_q <= 2'd0;
            ie_q    <= 1'b0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            ie_q    <= ie_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.PC     = pc_q;
    assign bus.Pc4    = pc4;
    assign bus.EPC    = epc_q;
    assign bus.Cause  = cause_q;
    assign bus.Status = {state_q == HANDLER, ie_q};
    assign bus.IntAck = ack_q;
endmodule

// File: tb/tb_pc_exc_unit.sv
// Scoreboarded bench for pc_exc_unit: directed scenarios, long branch climb, then random traffic.
module tb_pc_exc_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] VEC    = 32'h0000_0008;
`ifdef VECTORED_EXC_EN
    localparam logic [31:0] V_INT = VEC, V_UNI = VEC + 32'd8, V_OVF = VEC + 32'd16;
`else
    localparam logic [31:0] V_INT = VEC, V_UNI = VEC, V_OVF = VEC;
`endif

    typedef struct {
        logic        rst, stall, ovf, unimpl, eret, intr, sts_we;
        logic [1:0]  pcsrc, wdata;
        logic [15:0] imm;
        logic [25:0] jaddr;
    } stim_t;
    typedef struct {
        logic [31:0] pc, epc;
        logic [1:0]  cause, status;
        logic        ack;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1;
    pc_exc_unit_if bus();
    pc_exc_unit #(.RESET_PC(RST_PC), .EXC_VECTOR(VEC)) dut (.Clk(clk), .Rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    exp_t sb[$];
    // reference architectural state
    logic [31:0] m_pc, m_epc;
    logic [1:0]  m_cause;
    logic        m_ie, m_exl, m_pend, m_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] vec_of(input logic [1:0] c);
        case (c)
            2'd1:    return V_UNI;
            2'd2:    return V_OVF;
            default: return V_INT;
        endcase
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b0, stall: 1'b0, ovf: 1'b0, unimpl: 1'b0, eret: 1'b0, intr: 1'b0,
              sts_we: 1'b0, pcsrc: 2'b00, wdata: 2'b00, imm: 16'h0, jaddr: 26'h0};
        return s;
    endfunction

    task automatic model(input stim_t s);
        logic [31:0] npc, off;
        logic ok, took;
        if (s.rst) begin
            m_pc = RST_PC; m_epc = 0; m_cause = 0; m_ie = 0; m_exl = 0; m_pend = 0; m_ack = 0;
            return;
        end
        off = {{14{s.imm[15]}}, s.imm, 2'b00};
        if (s.pcsrc == 2'b10)      npc = m_pc + 32'd4 + off;
        else if (s.pcsrc == 2'b11) npc = {m_pc[31:28] + 4'd0, s.jaddr, 2'b00};
        else                       npc = m_pc + 32'd4;
        if (s.pcsrc == 2'b11) begin
            off = m_pc + 32'd4;
            npc = {off[31:28], s.jaddr, 2'b00};
        end
        ok = m_pend && m_ie && !m_exl;
        took = 1'b0;
        m_ack = 1'b0;
        if (!s.stall) begin
            if (s.ovf || s.unimpl) begin
                m_cause = s.ovf ? 2'd2 : 2'd1;
                if (!m_exl) m_epc = m_pc;
                m_exl = 1'b1;
                m_pc = vec_of(m_cause);
            end else if (ok) begin
                m_epc = npc; m_cause = 0; m_exl = 1; m_pc = vec_of(2'd0); m_ack = 1; took = 1;
            end else if (s.eret) begin
                m_pc = m_epc; m_exl = 0;
            end else if (s.sts_we) begin
                m_ie = s.wdata[0]; m_exl = s.wdata[1]; m_pc = npc;
            end else begin
                m_pc = npc;
            end
        end
        m_pend = (m_pend && !took) || s.intr;
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        rst = s.rst;
        bus.Stall = s.stall; bus.Pcsrc = s.pcsrc; bus.Imm16 = s.imm; bus.JAddr = s.jaddr;
        bus.Ovf = s.ovf; bus.Unimpl = s.unimpl; bus.Eret = s.eret; bus.Intr = s.intr;
        bus.Sts_we = s.sts_we; bus.Sts_wdata = s.wdata;
        model(s);
        e = '{pc: m_pc, epc: m_epc, cause: m_cause, status: {m_exl, m_ie}, ack: m_ack};
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) drive(idle());
    endtask

    // monitor: one expected record per clock edge, sampled on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_pc",     bus.PC,               e.pc);
                chk("sb_pc4",    bus.Pc4,              e.pc + 32'd4);
                chk("sb_epc",    bus.EPC,              e.epc);
                chk("sb_cause",  {30'd0, bus.Cause},   {30'd0, e.cause});
                chk("sb_status", {30'd0, bus.Status},  {30'd0, e.status});
                chk("sb_intack", {31'd0, bus.IntAck},  {31'd0, e.ack});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        logic [31:0] pc_save;
        s = idle(); s.rst = 1'b1; drive(s);
        chk("reset_pc", bus.PC, RST_PC);
        chk("reset_status", {30'd0, bus.Status}, 32'd0);
        nop(1); chk("seq4", bus.PC, 32'h4);
        nop(1); chk("seq8", bus.PC, 32'h8);
        nop(1); chk("seqC", bus.PC, 32'hC);
        s = idle(); s.pcsrc = 2'b10; s.imm = 16'hFFFE; drive(s);
        chk("branch_back", bus.PC, 32'h8);
        nop(6); chk("at20", bus.PC, 32'h20);
        // overflow, nested unimplemented, return
        s = idle(); s.ovf = 1'b1; drive(s);
        chk("ovf_pc", bus.PC, V_OVF); chk("ovf_epc", bus.EPC, 32'h20);
        chk("ovf_cause", {30'd0, bus.Cause}, 32'd2); chk("ovf_exl", {30'd0, bus.Status}, 32'd2);
        s = idle(); s.unimpl = 1'b1; drive(s);
        chk("nest_pc", bus.PC, V_UNI); chk("nest_epc", bus.EPC, 32'h20);
        chk("nest_cause", {30'd0, bus.Cause}, 32'd1);
        s = idle(); s.eret = 1'b1; drive(s);
        chk("eret_pc", bus.PC, 32'h20); chk("eret_status", {30'd0, bus.Status}, 32'd0);
        // masked interrupt then enable
        s = idle(); s.intr = 1'b1; drive(s);
        chk("masked_pc", bus.PC, 32'h24);
        nop(7); chk("at40", bus.PC, 32'h40);
        s = idle(); s.sts_we = 1'b1; s.wdata = 2'b01; drive(s);
        chk("sts_pc", bus.PC, 32'h44); chk("sts_ack", {31'd0, bus.IntAck}, 32'd0);
        nop(1);
        chk("int_pc", bus.PC, V_INT); chk("int_epc", bus.EPC, 32'h48);
        chk("int_cause", {30'd0, bus.Cause}, 32'd0); chk("int_ack", {31'd0, bus.IntAck}, 32'd1);
        nop(1); chk("ack_once", {31'd0, bus.IntAck}, 32'd0);
        s = idle(); s.eret = 1'b1; drive(s);
        chk("eret2_pc", bus.PC, 32'h48);
        // overflow and eligible interrupt on the same edge
        s = idle(); s.intr = 1'b1; drive(s);
        s = idle(); s.ovf = 1'b1; drive(s);
        chk("simul_pc", bus.PC, V_OVF); chk("simul_ack", {31'd0, bus.IntAck}, 32'd0);
        s = idle(); s.eret = 1'b1; drive(s);
        chk("simul_eret", bus.PC, 32'h4C);
        nop(1);
        chk("late_int_pc", bus.PC, V_INT); chk("late_int_ack", {31'd0, bus.IntAck}, 32'd1);
        s = idle(); s.eret = 1'b1; drive(s);
        // stall ignores overflow
        pc_save = bus.PC;
        s = idle(); s.stall = 1'b1; s.ovf = 1'b1; drive(s);
        chk("stall_pc", bus.PC, pc_save); chk("stall_cause", {30'd0, bus.Cause}, 32'd0);
        // reset from handler clears pending
        s = idle(); s.ovf = 1'b1; drive(s);
        s = idle(); s.intr = 1'b1; drive(s);
        s = idle(); s.rst = 1'b1; drive(s);
        chk("rst_hdl_pc", bus.PC, RST_PC); chk("rst_hdl_status", {30'd0, bus.Status}, 32'd0);
        s = idle(); s.sts_we = 1'b1; s.wdata = 2'b01; drive(s);
        nop(1); chk("pend_cleared", bus.PC, 32'h8);
        // wrap and long-range jump
        s = idle(); s.rst = 1'b1; drive(s);
        s = idle(); s.pcsrc = 2'b10; s.imm = 16'hFFFE; drive(s);
        chk("neg_branch", bus.PC, 32'hFFFF_FFFC);
        nop(1); chk("wrap", bus.PC, 32'h0);
        s = idle(); s.pcsrc = 2'b10; s.imm = 16'h7FFF;
        for (int i = 0; i < 2048; i++) drive(s);
        chk("climb", bus.PC, 32'h1000_0000);
        nop(4);
        s = idle(); s.pcsrc = 2'b11; s.jaddr = 26'h0000040; drive(s);
        chk("jump", bus.PC, 32'h1000_0100);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            s.rst    = ($urandom_range(199) == 0);
            s.stall  = ($urandom_range(7) == 0);
            s.ovf    = ($urandom_range(15) == 0);
            s.unimpl = ($urandom_range(15) == 0);
            s.eret   = ($urandom_range(9) == 0);
            s.intr   = ($urandom_range(7) == 0);
            s.sts_we = ($urandom_range(7) == 0);
            s.pcsrc  = 2'($urandom_range(3));
            s.wdata  = 2'($urandom_range(3));
            s.imm    = 16'($urandom);
            s.jaddr  = 26'($urandom);
            drive(s);
        end
        nop(1);
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
